// File: rtl/regfile_writeback.sv
// Per-thread write-back FIFO feeding the register file write port; drains one entry per UPDATE cycle.
// Publishes a busy mask and a RAW-hazard flag for registers with writes still pending.
module regfile_writeback #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [2:0]             core_state,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [3:0]             wr_rd,
  input  logic [1:0]             wr_mux,
  input  logic [DATA_BITS-1:0]   alu_out,
  input  logic [DATA_BITS-1:0]   lsu_out,
  input  logic [DATA_BITS-1:0]   imm,
  input  logic [3:0]             rs_address,
  input  logic [3:0]             rt_address,
  output logic                   wb_write_enable,
  output logic [3:0]             wb_rd_address,
  output logic [1:0]             wb_input_mux,
  output logic [DATA_BITS-1:0]   wb_data,
  output logic [15:0]            busy_mask,
  output logic                   hazard,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] UPDATE = 3'b110;

  logic [3:0]           r_rd   [DEPTH];
  logic [DATA_BITS-1:0] r_data [DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;

  logic                 w_accept;
  logic                 w_keep;
  logic                 w_drain;
  logic [DATA_BITS-1:0] w_sel;
  logic [CW-1:0]        w_count_nxt;
  logic [15:0]          w_busy;
  logic [PW-1:0]        w_off;

  assign wr_ready = enable & (r_count < CW'(DEPTH)) & ~flush;
  assign w_accept = wr_valid & wr_ready;
  // Writes to read-only R13..R15 or with an invalid source complete the handshake but are discarded.
  assign w_keep   = w_accept & (wr_rd < 4'd13) & (wr_mux != 2'b11);
  assign w_drain  = enable & ~flush & (r_count != '0) & (core_state == UPDATE);

  always_comb begin
    w_sel = alu_out;
    case (wr_mux)
      2'b01:   w_sel = lsu_out;
      2'b10:   w_sel = imm;
      default: w_sel = alu_out;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_keep && !w_drain)
      w_count_nxt = r_count + CW'(1);
    else if (!w_keep && w_drain)
      w_count_nxt = r_count - CW'(1);
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    w_busy = '0;
    w_off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rptr;
      if ({1'b0, w_off} < r_count)
        w_busy[r_rd[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_keep) begin
        r_rd[r_wptr]   <= wr_rd;
        r_data[r_wptr] <= w_sel;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_drain)
        r_rptr <= r_rptr + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  assign wb_write_enable = w_drain;
  assign wb_rd_address   = r_rd[r_rptr];
  assign wb_data         = r_data[r_rptr];
  assign wb_input_mux    = 2'b10;
  assign busy_mask       = w_busy;
  assign hazard          = w_busy[rs_address] | w_busy[rt_address];
  assign count           = r_count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;
  localparam int DB = 8;
  localparam int DEPTH = 4;

  logic clk = 0, reset = 0, enable = 1, flush = 0, wr_valid = 0;
  logic [2:0] core_state = 3'b000;
  logic [3:0] wr_rd = 0, rs_address = 0, rt_address = 0;
  logic [1:0] wr_mux = 0;
  logic [DB-1:0] alu_out = 0, lsu_out = 0, imm = 0;
  logic wr_ready, wb_write_enable, hazard;
  logic [3:0] wb_rd_address;
  logic [1:0] wb_input_mux;
  logic [DB-1:0] wb_data;
  logic [15:0] busy_mask;
  logic [2:0] count;

  int errors = 0, checks = 0;
  int q[$];

  regfile_writeback #(.DATA_BITS(DB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .core_state(core_state),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rd(wr_rd), .wr_mux(wr_mux),
    .alu_out(alu_out), .lsu_out(lsu_out), .imm(imm), .rs_address(rs_address),
    .rt_address(rt_address), .wb_write_enable(wb_write_enable), .wb_rd_address(wb_rd_address),
    .wb_input_mux(wb_input_mux), .wb_data(wb_data), .busy_mask(busy_mask), .hazard(hazard),
    .count(count));

  always #5 clk = ~clk;

  function automatic logic m_ready();
    return enable && !flush && (q.size() < DEPTH);
  endfunction
  function automatic logic m_drain();
    return reset && enable && !flush && (q.size() > 0) && (core_state == 3'b110);
  endfunction
  function automatic logic [15:0] m_busy();
    logic [15:0] b = '0;
    foreach (q[i]) b[(q[i] >> 8) & 15] = 1'b1;
    return b;
  endfunction
  function automatic logic m_hazard();
    logic [15:0] b = m_busy();
    return b[rs_address] | b[rt_address];
  endfunction
  function automatic logic [3:0] m_head_rd();
    return 4'((q[0] >> 8) & 15);
  endfunction
  function automatic logic [DB-1:0] m_head_data();
    return DB'(q[0] & 255);
  endfunction
  function automatic logic [DB-1:0] m_sel();
    case (wr_mux)
      2'b00: return alu_out;
      2'b01: return lsu_out;
      default: return imm;
    endcase
  endfunction

  // Advance one clock edge and apply the specified write-back rules to the model queue.
  task automatic tick();
    logic acc, dr;
    int ent;
    acc = wr_valid && m_ready();
    dr  = m_drain();
    ent = (int'(wr_rd) << 8) | int'(m_sel());
    @(posedge clk);
    if (!reset || flush) q.delete();
    else begin
      if (dr) void'(q.pop_front());
      if (acc && wr_rd < 13 && wr_mux != 2'b11) q.push_back(ent);
    end
    @(negedge clk);
  endtask

  task automatic post(input logic [3:0] rd, input logic [7:0] d, input logic [1:0] mux);
    wr_valid = 1; wr_rd = rd; wr_mux = mux;
    alu_out = DB'($urandom); lsu_out = DB'($urandom); imm = DB'($urandom);
    case (mux)
      2'b00: alu_out = d;
      2'b01: lsu_out = d;
      default: imm = d;
    endcase
  endtask

  task automatic test_reset();
    #1;
    checks += 7;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
    if (wb_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", wb_write_enable); end
    if (wb_rd_address !== 4'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", wb_rd_address); end
    if (wb_data !== 8'd0) begin errors++; $display("FAIL reset_data got=%h exp=00", wb_data); end
    if (busy_mask !== 16'd0) begin errors++; $display("FAIL reset_busy got=%h exp=0000", busy_mask); end
    if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    @(negedge clk); reset = 1; @(negedge clk);
  endtask

  task automatic test_single();
    core_state = 3'b000; rs_address = 3; rt_address = 0;
    post(3, 8'h2A, 2'b00); tick();
    wr_valid = 0; core_state = 3'b110; #1;
    checks += 6;
    if (wb_write_enable !== 1'b1) begin errors++; $display("FAIL single_we got=%b exp=1", wb_write_enable); end
    if (wb_rd_address !== 4'd3) begin errors++; $display("FAIL single_rd got=%0d exp=3", wb_rd_address); end
    if (wb_data !== 8'h2A) begin errors++; $display("FAIL single_data got=%h exp=2a", wb_data); end
    if (wb_input_mux !== 2'b10) begin errors++; $display("FAIL single_mux got=%b exp=10", wb_input_mux); end
    if (busy_mask !== 16'h0008 || hazard !== 1'b1) begin errors++; $display("FAIL single_busy_before got=%h/%b exp=0008/1", busy_mask, hazard); end
    if (count !== 3'd1) begin errors++; $display("FAIL single_count_before got=%0d exp=1", count); end
    tick(); #1;
    checks += 2;
    if (busy_mask !== 16'h0 || hazard !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%h/%b exp=0000/0", busy_mask, hazard); end
    if (count !== 3'd0 || wb_write_enable !== 1'b0) begin errors++; $display("FAIL single_after got=%0d/%b exp=0/0", count, wb_write_enable); end
  endtask

  task automatic test_fill();
    core_state = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      post(4'(k), 8'(k * 17), 2'($urandom_range(0, 2))); tick();
    end
    post(4'd9, 8'h99, 2'b00); #1;
    checks += 2;
    if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b exp=0", wr_ready); end
    tick(); wr_valid = 0; #1;
    checks++;
    if (count !== 3'd4) begin errors++; $display("FAIL fill_stall_count got=%0d exp=4", count); end
    core_state = 3'b110;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if (wb_write_enable !== 1'b1 || wb_rd_address !== 4'(k) || wb_data !== 8'(k * 17))
        begin errors++; $display("FAIL fill_drain%0d got=%b/%0d/%h exp=1/%0d/%h", k, wb_write_enable, wb_rd_address, wb_data, k, k * 17); end
      tick();
      if (k == 1) begin
        #1; checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after got=%b exp=1", wr_ready); end
      end
    end
  endtask

  task automatic test_drop();
    core_state = 3'b110;
    post(4'd14, 8'h55, 2'b00); #1;
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL drop_ro_ready got=%b exp=1", wr_ready); end
    tick();
    post(4'd0, 8'h66, 2'b11); #1;
    checks++;
    if (wr_ready !== 1'b1 || wb_write_enable !== 1'b0) begin errors++; $display("FAIL drop_inv got=%b/%b exp=1/0", wr_ready, wb_write_enable); end
    tick(); wr_valid = 0; #1;
    checks++;
    if (count !== 3'd0 || busy_mask !== 16'h0 || wb_write_enable !== 1'b0)
      begin errors++; $display("FAIL drop_after got=%0d/%h/%b exp=0/0000/0", count, busy_mask, wb_write_enable); end
  endtask

  task automatic test_same_rd();
    core_state = 3'b000; rs_address = 5; rt_address = 0;
    post(5, 8'h01, 2'b10); tick();
    post(5, 8'h02, 2'b01); tick();
    core_state = 3'b110; post(7, 8'h33, 2'b00); #1;
    checks++;
    if (hazard !== 1'b1 || wb_data !== 8'h01) begin errors++; $display("FAIL same_first got=%b/%h exp=1/01", hazard, wb_data); end
    tick(); wr_valid = 0; #1;
    checks += 2;
    if (count !== 3'd2) begin errors++; $display("FAIL same_acc_drain_count got=%0d exp=2", count); end
    if (hazard !== 1'b1 || wb_rd_address !== 4'd5 || wb_data !== 8'h02)
      begin errors++; $display("FAIL same_second got=%b/%0d/%h exp=1/5/02", hazard, wb_rd_address, wb_data); end
    tick(); #1;
    checks++;
    if (hazard !== 1'b0 || busy_mask !== 16'h0080) begin errors++; $display("FAIL same_clear got=%b/%h exp=0/0080", hazard, busy_mask); end
    tick();
  endtask

  task automatic test_flush_enable();
    core_state = 3'b000;
    for (int k = 0; k < 3; k++) begin post(4'(k + 8), 8'($urandom), 2'b00); tick(); end
    wr_valid = 0; core_state = 3'b110; flush = 1; #1;
    checks++;
    if (wb_write_enable !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL flush_cycle got=%b/%b exp=0/0", wb_write_enable, wr_ready); end
    tick(); flush = 0; core_state = 3'b000; #1;
    checks++;
    if (count !== 3'd0 || busy_mask !== 16'h0) begin errors++; $display("FAIL flush_after got=%0d/%h exp=0/0000", count, busy_mask); end
    for (int k = 0; k < 2; k++) begin post(4'(k + 1), 8'($urandom), 2'b01); tick(); end
    wr_valid = 0; enable = 0; core_state = 3'b110; #1;
    checks++;
    if (wb_write_enable !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL enable_low got=%b/%b exp=0/0", wb_write_enable, wr_ready); end
    tick(); tick(); #1;
    checks++;
    if (count !== 3'd2 || busy_mask !== m_busy()) begin errors++; $display("FAIL enable_hold got=%0d/%h exp=2/%h", count, busy_mask, m_busy()); end
    enable = 1; tick(); tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      core_state = ($urandom_range(0, 1) != 0) ? 3'b110 : 3'($urandom_range(0, 5));
      post(4'($urandom), 8'($urandom), 2'($urandom));
      wr_valid = $urandom_range(0, 1) != 0;
      rs_address = 4'($urandom); rt_address = 4'($urandom);
      #1;
      checks += 4;
      if (count !== 3'(q.size())) begin errors++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, count, q.size()); end
      if (wr_ready !== m_ready()) begin errors++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, wr_ready, m_ready()); end
      if (wb_write_enable !== m_drain()) begin errors++; $display("FAIL rand_we n=%0d got=%b exp=%b", n, wb_write_enable, m_drain()); end
      if (busy_mask !== m_busy() || hazard !== m_hazard())
        begin errors++; $display("FAIL rand_busy n=%0d got=%h/%b exp=%h/%b", n, busy_mask, hazard, m_busy(), m_hazard()); end
      if (m_drain()) begin
        checks++;
        if (wb_rd_address !== m_head_rd() || wb_data !== m_head_data())
          begin errors++; $display("FAIL rand_head n=%0d got=%0d/%h exp=%0d/%h", n, wb_rd_address, wb_data, m_head_rd(), m_head_data()); end
      end
      tick();
    end
    enable = 1; flush = 0; wr_valid = 0;
  endtask

  task automatic test_async_reset();
    flush = 1; tick(); flush = 0; core_state = 3'b000;
    for (int k = 0; k < 3; k++) begin post(4'(k + 2), 8'(k + 8'hA0), 2'b00); tick(); end
    wr_valid = 0; core_state = 3'b110; #1;
    checks++;
    if (wb_write_enable !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL areset_pre got=%b/%0d exp=1/3", wb_write_enable, count); end
    #1 reset = 0; q.delete(); #1;
    checks++;
    if (wb_write_enable !== 1'b0 || count !== 3'd0 || busy_mask !== 16'h0 || wb_data !== 8'h0 || wb_rd_address !== 4'h0)
      begin errors++; $display("FAIL areset_now got=%b/%0d/%h/%h/%0d exp=0/0/0000/00/0", wb_write_enable, count, busy_mask, wb_data, wb_rd_address); end
    tick(); reset = 1;
    for (int k = 0; k < 3; k++) begin
      #1; checks++;
      if (wb_write_enable !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL areset_post%0d got=%b/%0d exp=0/0", k, wb_write_enable, count); end
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_drop();
    test_same_rd();
    test_flush_enable();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Per-thread write-back queue that sits in front of a thread's register file write port. Execution units post register results (ALU, LSU or immediate) into a small FIFO; the block drains one entry per cycle into the register file during the core UPDATE state and publishes a busy mask and RAW-hazard flag so the scheduler can stall reads of registers that still have writes pending. It enforces the register file's write rules: R13–R15 read-only, one write per UPDATE cycle.

## Interface
Parameters:
- DATA_BITS, 8, register data width
- DEPTH, 4, queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; one clock; reset is asynchronous and active-low
- reset  in  1  asynchronous active-low reset
- enable  in  1  thread active; low freezes queue and blocks posting
- flush  in  1  synchronous queue clear (new block dispatch)
- core_state  in  3  core state encoding; UPDATE = 3'b110
- wr_valid  in  1  producer has a result
- wr_ready  out  1  queue can accept
- wr_rd  in  4  destination register
- wr_mux  in  2  source select: 00 ALU, 01 LSU, 10 immediate, 11 invalid
- alu_out, lsu_out, imm  in  DATA_BITS each  candidate data
- rs_address, rt_address  in  4 each  source registers of the instruction being decoded
- wb_write_enable  out  1  register file write strobe
- wb_rd_address  out  4  register file rd
- wb_input_mux  out  2  constant 2'b10 (CONSTANT path)
- wb_data  out  DATA_BITS  drives register file immediate input
- busy_mask  out  16  bit i set while any queued entry targets Ri
- hazard  out  1  busy_mask[rs_address] | busy_mask[rt_address]
- count  out  $clog2(DEPTH)+1  entries held

## Operation
- Entry = {rd[3:0], data[DATA_BITS-1:0]}; data selected at accept time from wr_mux (00 alu_out, 01 lsu_out, 10 imm).
- Accept: wr_valid & wr_ready at posedge. wr_ready = enable & (count < DEPTH) & !flush; no full-bypass even when draining same cycle.
- Dropped-but-accepted: wr_rd ≥ 13 or wr_mux = 11 handshake completes, nothing is queued, count unchanged.
- Drain: drain = enable & !flush & (count ≠ 0) & (core_state == UPDATE). Outputs combinational from head: wb_write_enable = drain, wb_rd_address = head.rd, wb_data = head.data; head popped at the same posedge the register file samples.
- Simultaneous accept and drain: both occur, count unchanged, FIFO order preserved.
- busy_mask: OR of one-hot(rd) over valid entries, combinational from queue state; same rd queued twice stays busy until the last one drains.
- flush: at posedge clears pointers and count; overrides accept and drain; wb_write_enable is 0 in a flush cycle.
- enable low: no accept, no drain, contents and count held.
- Read/write pointers wrap modulo DEPTH; count distinguishes full from empty.

## Timing
- Reset (asynchronous, reset = 0): pointers, count, all entry storage cleared; wr_ready = enable, wb_write_enable 0, wb_rd_address 0, wb_data 0, busy_mask 0, hazard 0, count 0. Reset mid-drain discards all entries; no write strobe during reset.
- Accept at edge N → entry at head (if queue was empty) and busy bit visible after N; earliest write strobe asserted in cycle N+1, committed at edge N+1, if core_state == UPDATE then.
- Throughput: one accept and one drain per cycle.
- busy bit for a drained rd clears after the drain edge; hazard follows combinationally.

## Test plan
- Reset then post ALU 0x2A to R3, core_state = UPDATE next cycle → wb_write_enable 1, wb_rd_address 3, wb_data 0x2A, wb_input_mux 10; busy_mask[3] 1 before, 0 after; count 1→0.
- Post R1,R2,R3,R4 (0x11..0x44) with core_state ≠ UPDATE → count 4, wr_ready 0, fifth post stalls; then UPDATE held 4 cycles → writes drain in order R1..R4, wr_ready 1 after first drain.
- Post to R14 (0x55) and wr_mux = 11 to R0 → both handshakes complete, count stays 0, no write strobe, busy_mask 0.
- Queue R5 twice (0x01, 0x02), rs_address 5 → hazard 1 until second drain, final wb_data 0x02; accept+drain same cycle with count 2 keeps count 2.
- With 3 entries queued, assert flush during UPDATE → no strobe that cycle, count 0, busy_mask 0 next cycle; enable low with 2 entries during UPDATE → no drain, count held.
- Drop reset mid-queue (3 entries) asynchronously between edges → outputs zero immediately, no writes after release.
